pool_frame_ctrl: RTL

- Frame sequencer for the shared 4-lane pool_relu_wrapper (2x2 max-pool + ReLU over rows of W pixels).
- Accepts one conv-output frame (H rows x W beats, 4 lanes x In_d_W bits per beat) on a valid/ready stream and clears the pool at frame start.
- Gates input by downstream credit, because the pool has no backpressure; buffers pool results in an output FIFO; tags the last output; reports done and errors.

---
 rtl/cnn_pool_pkg.sv | 30 +++
 rtl/pool_out_fifo.sv | 53 +++++
 rtl/pool_frame_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cnn_pool_pkg.sv
// Shared types and helpers for the pool frame sequencer.
// Lane layout on every bus is {ch3, ch2, ch1, ch0}, each lane In_d_W bits wide.
package cnn_pool_pkg;

  localparam int unsigned LANES = 4;

  typedef enum logic [2:0] {
    StIdle,
    StClrPool,
    StFeed,
    StDrain,
    StDone
  } pool_state_e;

  // Number of pooled outputs in one w x h frame.
  function automatic int unsigned out_total(input int unsigned w, input int unsigned h);
    return (w / 2) * (h / 2);
  endfunction

  // Bit offset of a lane inside a packed lane bus.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned lane_w);
    return lane * lane_w;
  endfunction

  // Highest bit of a lane inside a packed lane bus.
  function automatic int unsigned lane_hi(input int unsigned lane, input int unsigned lane_w);
    return lane_lo(lane, lane_w) + lane_w - 1;
  endfunction

endpackage

// File: rtl/pool_out_fifo.sv
// Synchronous FIFO for pooled results; head entry is read straight from the storage array.
// A write while full succeeds only if a read frees a slot in the same cycle.
module pool_out_fifo #(
  parameter int unsigned Width = 129,
  parameter int unsigned Depth = 16
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [Width-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [Width-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned CountW = $clog2(Depth + 1);

  logic [Width-1:0]  mem [Depth];
  logic [AddrW-1:0]  wptr_q, rptr_q;
  logic [CountW-1:0] count_q;
  logic              do_wr, do_rd;

  assign full  = (count_q == CountW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem[rptr_q];

  always_ff @(posedge clk) begin
    if (clr || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + AddrW'(1);
      if (do_rd) rptr_q <= rptr_q + AddrW'(1);
      count_q <= count_q + CountW'(do_wr) - CountW'(do_rd);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/pool_frame_ctrl.sv
// Frame sequencer for the shared 4-lane max-pool + ReLU wrapper: feeds one frame,
// meters input by output FIFO credit (the pool cannot stall) and tags the final result.
module pool_frame_ctrl
  import cnn_pool_pkg::*;
#(
  parameter int unsigned In_d_W     = 32,
  parameter int unsigned W          = 26,
  parameter int unsigned H          = 26,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic [LANES-1:0]         cfg_ch_mask,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               err,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [LANES*In_d_W-1:0]  s_data,
  input  logic                     s_last,
  output logic                     pool_clr,
  output logic [LANES-1:0]         pool_in_valid,
  output logic [LANES*In_d_W-1:0]  pool_in_data,
  input  logic [LANES-1:0]         pool_out_valid,
  input  logic [LANES*In_d_W-1:0]  pool_out_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [LANES*In_d_W-1:0]  m_data,
  output logic                     m_last
);

  localparam int unsigned DataW  = LANES * In_d_W;
  localparam int unsigned Total  = out_total(W, H);
  localparam int unsigned CredW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ColW   = $clog2(W);
  localparam int unsigned RowW   = $clog2(H);
  localparam int unsigned OutCW  = $clog2(Total + 1);

  pool_state_e      state_q;
  logic [LANES-1:0] mask_q;
  logic [CredW-1:0] credits_q, credits_d;
  logic [ColW-1:0]  col_q;
  logic [RowW-1:0]  row_q;
  logic [OutCW-1:0] out_cnt_q;
  logic [1:0]       err_q;
  logic             busy_q, done_q;

  logic             producing, last_beat, accept, credit_take;
  logic             pop, capture, cap_last, drop, fifo_flush;
  logic             fifo_full, fifo_empty;
  logic [DataW:0]   fifo_rd;
  logic [CredW-1:0] fifo_count;
  logic             unused_fifo_count;

  // A beat on an odd row and odd column completes a 2x2 window.
  assign producing = row_q[0] & col_q[0];
  assign last_beat = (row_q == RowW'(H - 1)) && (col_q == ColW'(W - 1));

  assign s_ready     = (state_q == StFeed) && (!producing || (credits_q != '0));
  assign accept      = s_valid && s_ready;
  assign credit_take = accept && producing;

  assign pool_in_valid = accept ? mask_q : '0;
  assign pool_in_data  = s_data;
  assign pool_clr      = clr || (state_q == StClrPool);

  assign pop        = m_valid && m_ready;
  assign capture    = (pool_out_valid != '0) && ((state_q == StFeed) || (state_q == StDrain));
  assign cap_last   = (out_cnt_q == OutCW'(Total - 1));
  assign drop       = capture && fifo_full && !pop;
  assign fifo_flush = (state_q == StIdle) && start;

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_rd[DataW-1:0];
  assign m_last  = m_valid && fifo_rd[DataW];

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  assign unused_fifo_count = ^fifo_count;

  pool_out_fifo #(
    .Width (DataW + 1),
    .Depth (FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .clr     (clr),
    .flush   (fifo_flush),
    .wr_en   (capture),
    .wr_data ({cap_last, pool_out_data}),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // One credit per free FIFO slot, including slots reserved by results still in the pool.
  always_comb begin
    credits_d = credits_q;
    if (credit_take && !pop) begin
      credits_d = credits_q - CredW'(1);
    end else if (pop && !credit_take && (credits_q != CredW'(FIFO_DEPTH))) begin
      credits_d = credits_q + CredW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      credits_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      out_cnt_q <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      credits_q <= credits_d;
      if (capture) out_cnt_q <= out_cnt_q + OutCW'(1);
      if (drop) err_q[1] <= 1'b1;
      if (accept && (s_last != last_beat)) err_q[0] <= 1'b1;

      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= StClrPool;
            mask_q    <= cfg_ch_mask;
            credits_q <= CredW'(FIFO_DEPTH);
            out_cnt_q <= '0;
            err_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            busy_q    <= 1'b1;
          end
        end
        StClrPool: begin
          state_q <= StFeed;
        end
        StFeed: begin
          if (accept) begin
            if (last_beat) begin
              col_q   <= '0;
              row_q   <= '0;
              state_q <= StDrain;
            end else if (col_q == ColW'(W - 1)) begin
              col_q <= '0;
              row_q <= row_q + RowW'(1);
            end else begin
              col_q <= col_q + ColW'(1);
            end
          end
        end
        StDrain: begin
          if (pop && m_last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
